// File: rtl/ls256_pkg.sv
// rtl/ls256_pkg.sv - mode encoding shared by the 74LS256 addressable latch model
package ls256_pkg;

    // Modes are decoded from {CLR_n, EN_n}.
    localparam logic [1:0] MODE_DEMUX = 2'b00;
    localparam logic [1:0] MODE_CLEAR = 2'b01;
    localparam logic [1:0] MODE_LATCH = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    function automatic logic is_write(input logic [1:0] mode);
        return (mode == MODE_LATCH) || (mode == MODE_DEMUX);
    endfunction

endpackage

// File: rtl/ls256_section.sv
// rtl/ls256_section.sv - one 4-bit addressable latch section
module ls256_section
    import ls256_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [1:0] addr,
    input  logic       d,
    output logic [3:0] q
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    // An unknown address matches no case item, so the register holds.
    always_comb begin
        q_d = q_q;
        case (mode)
            MODE_LATCH: begin
                case (addr)
                    2'd0:    q_d[0] = d;
                    2'd1:    q_d[1] = d;
                    2'd2:    q_d[2] = d;
                    2'd3:    q_d[3] = d;
                    default: q_d = q_q;
                endcase
            end
            MODE_DEMUX: begin
                case (addr)
                    2'd0:    q_d = {3'b000, d};
                    2'd1:    q_d = {2'b00, d, 1'b0};
                    2'd2:    q_d = {1'b0, d, 2'b00};
                    2'd3:    q_d = {d, 3'b000};
                    default: q_d = q_q;
                endcase
            end
            MODE_CLEAR: q_d = 4'b0000;
            default:    q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 4'b0000;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/top_74ls256.sv
// rtl/top_74ls256.sv - dual 4-bit addressable latch with sequential auto-address load
module top_74ls256
    import ls256_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    input  logic       EN_n,
    input  logic       CLR_n,
    input  logic       SEQ,
    input  logic       D1,
    input  logic       D2,
    output logic [3:0] Q1,
    output logic [3:0] Q2,
    output logic       DONE
);

    logic [1:0] mode;
    logic [1:0] addr;
    logic       write;

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;
    logic       done_q;
    logic       done_d;

    assign mode  = {CLR_n, EN_n};
    assign addr  = SEQ ? cnt_q : {B, A};
    assign write = is_write(mode);

    // Leaving SEQ mode parks the counter so the next load starts at address 0.
    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (!SEQ) begin
            cnt_d = 2'd0;
        end else if (mode == MODE_CLEAR) begin
            cnt_d = 2'd0;
        end else if (write) begin
            cnt_d  = cnt_q + 2'd1;
            done_d = (cnt_q == 2'd3);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    ls256_section u_sec1 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .addr  (addr),
        .d     (D1),
        .q     (Q1)
    );

    ls256_section u_sec2 (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .addr  (addr),
        .d     (D2),
        .q     (Q2)
    );

    assign DONE = done_q;

endmodule

// File: tb/tb_top_74ls256.sv
// tb/tb_top_74ls256.sv - scoreboard bench for top_74ls256 against a behavioural model
module tb_top_74ls256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       A = 1'b0;
    logic       B = 1'b0;
    logic       EN_n = 1'b1;
    logic       CLR_n = 1'b1;
    logic       SEQ = 1'b0;
    logic       D1 = 1'b0;
    logic       D2 = 1'b0;
    logic [3:0] Q1;
    logic [3:0] Q2;
    logic       DONE;

    always #5 clk = ~clk;

    top_74ls256 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (A),
        .B     (B),
        .EN_n  (EN_n),
        .CLR_n (CLR_n),
        .SEQ   (SEQ),
        .D1    (D1),
        .D2    (D2),
        .Q1    (Q1),
        .Q2    (Q2),
        .DONE  (DONE)
    );

    typedef struct {
        logic [3:0] q1;
        logic [3:0] q2;
        logic       done;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   n_id   = 0;

    // Reference state: two 4-bit words, a load pointer and the completion flag.
    logic [3:0] m_q1 = 4'b0000;
    logic [3:0] m_q2 = 4'b0000;
    int         m_ptr = 0;
    logic       m_done = 1'b0;

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got Q1/Q2/DONE=%b expected %b", nm, act, exp);
    endtask

    task automatic model_reset();
        m_q1 = 4'b0000;
        m_q2 = 4'b0000;
        m_ptr = 0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input bit en_n, input bit clr_n, input bit seq,
                              input bit a, input bit b, input bit d1, input bit d2);
        int  where;
        bit  wr;
        bit  clr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        where  = seq ? m_ptr : (2 * int'(b) + int'(a));
        wr     = !en_n;
        clr    = !clr_n && en_n;
        m_done = seq && wr && (m_ptr == 3);
        if (wr) begin
            if (!clr_n) begin
                m_q1 = 4'b0000;
                m_q2 = 4'b0000;
            end
            m_q1[where] = d1;
            m_q2[where] = d2;
        end
        if (clr) begin
            m_q1 = 4'b0000;
            m_q2 = 4'b0000;
        end
        if (!seq || clr) m_ptr = 0;
        else if (wr)     m_ptr = (m_ptr + 1) % 4;
    endtask

    task automatic drive(input bit r, input bit en_n, input bit clr_n, input bit seq,
                         input bit a, input bit b, input bit d1, input bit d2);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        EN_n  = en_n;
        CLR_n = clr_n;
        SEQ   = seq;
        A     = a;
        B     = b;
        D1    = d1;
        D2    = d2;
        model_step(en_n, clr_n, seq, a, b, d1, d2);
        e.q1 = m_q1;
        e.q2 = m_q2;
        e.done = m_done;
        e.id = n_id;
        n_id++;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk($sformatf("step%0d", e.id), {Q1, Q2, DONE}, {e.q1, e.q2, e.done});
            end
        end
    end

    initial begin
        bit d1s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        bit d2s[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        int seq_run;

        #12;
        chk("reset_state", {Q1, Q2, DONE}, 9'b0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // addressable latch: addr 2 then addr 0
        drive(1, 0, 1, 0, 0, 1, 1, 0);
        drive(1, 0, 1, 0, 0, 0, 1, 0);
        // memory mode with wiggling inputs
        for (int i = 0; i < 5; i++)
            drive(1, 1, 1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        // demux at addr 3, then clear
        drive(1, 0, 0, 0, 1, 1, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 1, 1);

        // sequential load, a wrapping 5th write, then an idle cycle
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 1, 0, 0, d1s[i], d2s[i]);
        drive(1, 0, 1, 1, 1, 1, 0, 1);
        drive(1, 1, 1, 1, 0, 0, 0, 0);

        // SEQ dropped mid-load, then restarted
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        drive(1, 0, 1, 1, 0, 0, 1, 1);
        drive(1, 0, 1, 1, 0, 0, 0, 1);
        drive(1, 0, 1, 0, 1, 0, 1, 0);
        drive(1, 0, 1, 1, 0, 0, 1, 1);

        // clear arriving while the pointer sits at 3
        drive(1, 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 0, 1, 1, 0, 0, 1, 1);
        drive(1, 1, 0, 1, 0, 0, 1, 1);
        drive(1, 0, 1, 1, 0, 0, 1, 0);

        // fill Q1 with ones, then reset asynchronously between edges
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 0, i[0], i[1], 1, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset", {Q1, Q2, DONE}, 9'b0);
        model_reset();
        drive(0, 0, 1, 1, 0, 0, 1, 1);
        drive(1, 0, 1, 1, 0, 0, 1, 1);

        // randomized traffic with runs of sequential loading
        seq_run = 0;
        for (int i = 0; i < 400; i++) begin
            bit r;
            bit seq;
            if (seq_run == 0) seq_run = $urandom_range(1, 12);
            seq_run--;
            seq = (seq_run % 2 == 0) ? 1'($urandom_range(0, 3) != 0) : 1'b1;
            r = ($urandom_range(0, 60) != 0);
            drive(r, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) != 0), seq,
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
